// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for lock with a bounded
// timeout and retry budget, then requires a stable lock window before
// declaring the output clock ready. A lock loss in RUN restarts the sequence.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       req_restart,
  output logic       pll_rst,
  output logic       clk_ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  // Counters are sized so their terminal value always fits; they stop at
  // terminal and are cleared on every state change, so they never wrap.
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t        cur, state_n;
  logic [RW-1:0] rst_cnt, rst_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [SW-1:0] stb_cnt, stb_cnt_n;
  logic [3:0]    retry_n;
  logic [1:0]    sync_q;
  logic          locked_s;

  assign locked_s = sync_q[1];
  assign state    = cur;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], pll_locked};
  end

  // State, counters and registered outputs; outputs are decoded from the
  // next state so they change on the same edge as the state register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= RESET_PLL;
      rst_cnt     <= '0;
      to_cnt      <= '0;
      stb_cnt     <= '0;
      retry_count <= 4'd0;
      pll_rst     <= 1'b1;
      clk_ready   <= 1'b0;
      fail        <= 1'b0;
    end else begin
      cur         <= state_n;
      rst_cnt     <= rst_cnt_n;
      to_cnt      <= to_cnt_n;
      stb_cnt     <= stb_cnt_n;
      retry_count <= retry_n;
      pll_rst     <= (state_n == RESET_PLL) || (state_n == FAIL);
      clk_ready   <= (state_n == RUN);
      fail        <= (state_n == FAIL);
    end
  end

  // Next-state and counter logic; restart overrides every other event.
  always_comb begin
    state_n   = cur;
    rst_cnt_n = rst_cnt;
    to_cnt_n  = to_cnt;
    stb_cnt_n = stb_cnt;
    retry_n   = retry_count;
    if (req_restart) begin
      state_n   = RESET_PLL;
      rst_cnt_n = '0;
      to_cnt_n  = '0;
      stb_cnt_n = '0;
      retry_n   = 4'd0;
    end else begin
      case (cur)
        RESET_PLL: begin
          if (rst_cnt == RST_LAST) begin
            state_n   = WAIT_LOCK;
            rst_cnt_n = '0;
            to_cnt_n  = '0;
          end else begin
            rst_cnt_n = rst_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_n   = STABLE;
            stb_cnt_n = '0;
            to_cnt_n  = '0;
          end else if (to_cnt == TO_LAST) begin
            to_cnt_n = '0;
            if (retry_count == RETRY_MAX) begin
              state_n = FAIL;
            end else begin
              state_n   = RESET_PLL;
              rst_cnt_n = '0;
              retry_n   = retry_count + 4'd1;
            end
          end else begin
            to_cnt_n = to_cnt + 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            // Glitch: start over waiting for lock, retry budget untouched.
            state_n   = WAIT_LOCK;
            to_cnt_n  = '0;
            stb_cnt_n = '0;
          end else if (stb_cnt == STB_LAST) begin
            state_n   = RUN;
            stb_cnt_n = '0;
            retry_n   = 4'd0;
          end else begin
            stb_cnt_n = stb_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_n   = RESET_PLL;
            rst_cnt_n = '0;
          end
        end
        FAIL: begin
          // Absorbing; only restart or reset leaves.
          state_n = FAIL;
        end
        default: begin
          state_n   = RESET_PLL;
          rst_cnt_n = '0;
          to_cnt_n  = '0;
          stb_cnt_n = '0;
        end
      endcase
    end
  end

endmodule
